// File: rtl/conv_egress_if.sv
// conv_pkg: pixel and kernel-position tag types shared by the engine and its egress.
// conv_egress_if: the core-result bus plus the downstream AXI4-Stream bus.
// Modports: master = egress view (drives core_rdy_o and m_t*), slave = environment view.
package conv_pkg;
  localparam int PIXEL_W = 8;

  typedef logic [PIXEL_W-1:0] pixel_t;

  // Border flags of the kernel window centre relative to the frame.
  // n2: top row, s2: bottom row, w2: left column, e2: right column.
  typedef struct packed {
    logic n2;
    logic s2;
    logic w2;
    logic e2;
  } kernel_pos_t;
endpackage

interface conv_egress_if;
  import conv_pkg::*;

  logic        core_vld_i;
  pixel_t      core_dat_i;
  kernel_pos_t core_pos_i;
  logic        core_rdy_o;
  logic        m_tvalid_o;
  pixel_t      m_tdata_o;
  logic        m_tuser_o;
  logic        m_tlast_o;
  logic        m_tready_i;

  modport master (
    input  core_vld_i, core_dat_i, core_pos_i, m_tready_i,
    output core_rdy_o, m_tvalid_o, m_tdata_o, m_tuser_o, m_tlast_o
  );

  modport slave (
    output core_vld_i, core_dat_i, core_pos_i, m_tready_i,
    input  core_rdy_o, m_tvalid_o, m_tdata_o, m_tuser_o, m_tlast_o
  );
endinterface

// File: rtl/conv_egress.sv
// conv_egress: AXI4-Stream transmitter for convolution results. Tags each pixel with
// SOF/EOL, buffers it in a first-word-fall-through FIFO, drives the AXIS master, raises
// early back-pressure (core_rdy_o) and checks per-frame line-length consistency.
// Ports: clk/arst (async, active high); bus (conv_egress_if.master: core_* in, m_t* out);
// err_o sticky {ovf, len, sof}; frame_cnt_o/line_cnt_o live only with CONV_EGRESS_STATS_EN.
// Latency: one cycle from push to m_tvalid_o on an empty FIFO.
module conv_egress
  import conv_pkg::*;
#(
  parameter int DEPTH = 8,   // power of two, >= SKID+2
  parameter int SKID  = 4,   // beats the engine may still emit after core_rdy_o drops
  parameter int COL_W = 12
) (
  input  logic          clk,
  input  logic          arst,
  conv_egress_if.master bus,
  output logic [2:0]    err_o,
  output logic [15:0]   frame_cnt_o,
  output logic [15:0]   line_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]    DEPTH_L = CW'(DEPTH);
  localparam logic [CW-1:0]    SKID_L  = CW'(SKID);
  localparam logic [COL_W-1:0] COL_MAX = '1;

  typedef struct packed {
    logic   sof;
    logic   eol;
    pixel_t dat;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE, S_LEARN, S_CHECK} state_t;

  // ---------------- FIFO ----------------
  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  entry_t head;
  entry_t wr_ent;
  logic   empty, full, pop, push_ok, ovf;

  // The s2 flag carries no meaning at the egress.
  logic unused_pos_s2;
  assign unused_pos_s2 = bus.core_pos_i.s2;

  assign wr_ent.sof = bus.core_pos_i.n2 & bus.core_pos_i.w2;
  assign wr_ent.eol = bus.core_pos_i.e2;
  assign wr_ent.dat = bus.core_dat_i;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == DEPTH_L);
  assign pop     = ~empty & bus.m_tready_i;
  // A full FIFO still takes a beat when the head leaves in the same cycle.
  assign push_ok = bus.core_vld_i & (~full | pop);
  assign ovf     = bus.core_vld_i & full & ~pop;

  assign head = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_ok && !pop)      cnt_d = cnt_q + CW'(1);
    else if (!push_ok && pop) cnt_d = cnt_q - CW'(1);
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_ent;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.m_tvalid_o = ~empty;
  assign bus.m_tdata_o  = head.dat;
  assign bus.m_tuser_o  = head.sof;
  assign bus.m_tlast_o  = head.eol;

  // Early back-pressure from the registered count leaves SKID entries for the
  // beats already in the engine pipeline when it sees core_rdy_o fall.
  assign bus.core_rdy_o = (DEPTH_L - cnt_q) > SKID_L;

  // ---------------- line checker ----------------
  state_t           state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [COL_W:0]   width_q, width_d;   // one bit wider: holds col+1 at saturation
  logic [2:0]       err_q, err_d;
  logic [COL_W-1:0] col_inc;
  logic [COL_W:0]   col_p1;
  logic             col_sat;

  assign col_sat = (col_q == COL_MAX);
  assign col_inc = col_sat ? col_q : col_q + COL_W'(1);
  assign col_p1  = {1'b0, col_q} + (COL_W+1)'(1);

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    width_d = width_q;
    err_d   = err_q;
    if (ovf) err_d[2] = 1'b1;
    if (pop) begin
      if (head.sof) begin
        // A new frame always relearns the width; the sof beat is column 0.
        state_d = S_LEARN;
        col_d   = head.eol ? '0 : COL_W'(1);
      end else begin
        case (state_q)
          S_IDLE: err_d[0] = 1'b1;
          S_LEARN: begin
            if (head.eol) begin
              width_d = col_p1;
              col_d   = '0;
              state_d = S_CHECK;
              if (col_sat) err_d[1] = 1'b1;
            end else begin
              col_d = col_inc;
            end
          end
          S_CHECK: begin
            if (head.eol) begin
              if (col_p1 != width_q || col_sat) err_d[1] = 1'b1;
              col_d = '0;
            end else begin
              col_d = col_inc;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      width_q <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      width_q <= width_d;
      err_q   <= err_d;
    end
  end

  assign err_o = err_q;

  // ---------------- optional statistics ----------------
`ifdef CONV_EGRESS_STATS_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] line_cnt_q, line_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    line_cnt_d  = line_cnt_q;
    if (pop && head.sof) frame_cnt_d = frame_cnt_q + 16'd1;
    if (pop && head.eol) line_cnt_d  = line_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      frame_cnt_q <= '0;
      line_cnt_q  <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      line_cnt_q  <= line_cnt_d;
    end
  end

  assign frame_cnt_o = frame_cnt_q;
  assign line_cnt_o  = line_cnt_q;
`else
  assign frame_cnt_o = '0;
  assign line_cnt_o  = '0;
`endif

endmodule
